// File: rtl/tictactoe_turn_ctrl.sv
// Turn-sequencing controller placed in front of a tictactoe core.
// Arbitrates move requests from two players with strict X/O alternation,
// validates coordinates and occupancy against the core board, strobes the
// core for one cycle, waits for the core to settle, and reports per-move
// status plus the final game result. Owns core reset / game restart and
// forfeits a player who idles past TIMEOUT_CYCLES.
//
// Ports:
//   clk_i, rst_i (sync, active-high), new_game_i (sync restart pulse)
//   p1_valid_i/p1_x_i/p1_y_i/p1_ready_o : player X request handshake
//   p2_valid_i/p2_x_i/p2_y_i/p2_ready_o : player O request handshake
//   core_rst_n_o, core_x_o, core_y_o, core_make_move_o : drive the core
//   core_board_i, core_winner_i, core_tie_i              : core status
//   resp_valid_o/resp_player_o/resp_code_o : one-cycle status pulse
//   turn_o, move_count_o, game_over_o, result_o          : game status
module tictactoe_turn_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        new_game_i,
  input  logic        p1_valid_i,
  input  logic [3:0]  p1_x_i,
  input  logic [3:0]  p1_y_i,
  output logic        p1_ready_o,
  input  logic        p2_valid_i,
  input  logic [3:0]  p2_x_i,
  input  logic [3:0]  p2_y_i,
  output logic        p2_ready_o,
  output logic        core_rst_n_o,
  output logic [3:0]  core_x_o,
  output logic [3:0]  core_y_o,
  output logic        core_make_move_o,
  input  logic [17:0] core_board_i,
  input  logic [1:0]  core_winner_i,
  input  logic        core_tie_i,
  output logic        resp_valid_o,
  output logic [1:0]  resp_player_o,
  output logic [2:0]  resp_code_o,
  output logic [1:0]  turn_o,
  output logic [3:0]  move_count_o,
  output logic        game_over_o,
  output logic [1:0]  result_o
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] PL_X = 2'b01;
  localparam logic [1:0] PL_O = 2'b10;

  localparam logic [2:0] RC_OK       = 3'd0;
  localparam logic [2:0] RC_BAD      = 3'd1;
  localparam logic [2:0] RC_OCC      = 3'd2;
  localparam logic [2:0] RC_OVER     = 3'd3;
  localparam logic [2:0] RC_TIMEOUT  = 3'd4;

  typedef enum logic [2:0] {
    S_CLEAR, S_WAIT, S_CHECK, S_ISSUE, S_SETTLE, S_EVAL, S_DONE
  } state_e;

  state_e        state_q;
  logic          clr_cnt_q;
  logic [SW-1:0] set_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [3:0]    x_q, y_q;
  logic          pend_o_q;
  logic          core_rst_n_q, core_mm_q;
  logic [3:0]    core_x_q, core_y_q;
  logic          resp_valid_q;
  logic [1:0]    resp_player_q;
  logic [2:0]    resp_code_q;
  logic [1:0]    turn_q;
  logic [3:0]    move_count_q;
  logic          game_over_q;
  logic [1:0]    result_q;
  logic          p1_ready_q, p2_ready_q;

  logic        hs1, hs2;
  logic        bad_coord, occupied;
  logic [3:0]  cell_k;
  logic [17:0] board_sh;

  assign hs1 = p1_valid_i & p1_ready_q;
  assign hs2 = p2_valid_i & p2_ready_q;

  // Cell k lives at bits [17-2k:16-2k]; shifting left by 2k brings it to the
  // top two bits. Only meaningful when the coordinates are in range.
  always_comb begin
    bad_coord = (x_q > 4'd2) || (y_q > 4'd2);
    cell_k    = x_q * 4'd3 + y_q;
    board_sh  = core_board_i << {cell_k, 1'b0};
    occupied  = |board_sh[17:16];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || new_game_i) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= 1'b0;
      set_cnt_q     <= '0;
      to_cnt_q      <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pend_o_q      <= 1'b0;
      core_rst_n_q  <= 1'b0;
      core_mm_q     <= 1'b0;
      core_x_q      <= '0;
      core_y_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_player_q <= '0;
      resp_code_q   <= '0;
      turn_q        <= PL_X;
      move_count_q  <= '0;
      game_over_q   <= 1'b0;
      result_q      <= '0;
      p1_ready_q    <= 1'b0;
      p2_ready_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      core_mm_q    <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (clr_cnt_q) begin
            core_rst_n_q <= 1'b1;
            state_q      <= S_WAIT;
            p1_ready_q   <= (turn_q == PL_X);
            p2_ready_q   <= (turn_q == PL_O);
          end else begin
            clr_cnt_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (hs1 || hs2) begin
            x_q        <= hs1 ? p1_x_i : p2_x_i;
            y_q        <= hs1 ? p1_y_i : p2_y_i;
            to_cnt_q   <= '0;
            p1_ready_q <= 1'b0;
            p2_ready_q <= 1'b0;
            state_q    <= S_CHECK;
          end else if (to_cnt_q == TO_LAST) begin
            // Idle forfeit: the other player wins.
            resp_valid_q  <= 1'b1;
            resp_code_q   <= RC_TIMEOUT;
            resp_player_q <= turn_q;
            result_q      <= ~turn_q;
            game_over_q   <= 1'b1;
            p1_ready_q    <= 1'b1;
            p2_ready_q    <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (bad_coord || occupied) begin
            resp_valid_q  <= 1'b1;
            resp_code_q   <= bad_coord ? RC_BAD : RC_OCC;
            resp_player_q <= turn_q;
            p1_ready_q    <= (turn_q == PL_X);
            p2_ready_q    <= (turn_q == PL_O);
            state_q       <= S_WAIT;
          end else begin
            core_mm_q <= 1'b1;
            core_x_q  <= x_q;
            core_y_q  <= y_q;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          set_cnt_q <= '0;
          state_q   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (set_cnt_q == SET_LAST) state_q <= S_EVAL;
          else                       set_cnt_q <= set_cnt_q + 1'b1;
        end
        S_EVAL: begin
          move_count_q  <= move_count_q + 4'd1;
          resp_valid_q  <= 1'b1;
          resp_code_q   <= RC_OK;
          resp_player_q <= turn_q;
          if (core_winner_i != 2'b00) begin
            result_q    <= core_winner_i;
            game_over_q <= 1'b1;
            p1_ready_q  <= 1'b1;
            p2_ready_q  <= 1'b1;
            state_q     <= S_DONE;
          end else if (core_tie_i || move_count_q == 4'd8) begin
            result_q    <= 2'b11;
            game_over_q <= 1'b1;
            p1_ready_q  <= 1'b1;
            p2_ready_q  <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            turn_q     <= ~turn_q;
            p1_ready_q <= (turn_q == PL_O);
            p2_ready_q <= (turn_q == PL_X);
            state_q    <= S_WAIT;
          end
        end
        S_DONE: begin
          // Accepting player's ready drops for one cycle. A simultaneous
          // X+O request answers X now and O on the following cycle, which
          // is safe because both readies are low during that cycle.
          p1_ready_q <= ~hs1;
          p2_ready_q <= ~hs2;
          if (pend_o_q) begin
            resp_valid_q  <= 1'b1;
            resp_code_q   <= RC_OVER;
            resp_player_q <= PL_O;
            pend_o_q      <= 1'b0;
          end else if (hs1) begin
            resp_valid_q  <= 1'b1;
            resp_code_q   <= RC_OVER;
            resp_player_q <= PL_X;
            pend_o_q      <= hs2;
          end else if (hs2) begin
            resp_valid_q  <= 1'b1;
            resp_code_q   <= RC_OVER;
            resp_player_q <= PL_O;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign p1_ready_o       = p1_ready_q;
  assign p2_ready_o       = p2_ready_q;
  assign core_rst_n_o     = core_rst_n_q;
  assign core_x_o         = core_x_q;
  assign core_y_o         = core_y_q;
  assign core_make_move_o = core_mm_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_player_o    = resp_player_q;
  assign resp_code_o      = resp_code_q;
  assign turn_o           = turn_q;
  assign move_count_o     = move_count_q;
  assign game_over_o      = game_over_q;
  assign result_o         = result_q;

endmodule

// File: doc/tictactoe_turn_ctrl.md
Name: tictactoe_turn_ctrl

Overview:
- Turn-sequencing controller in front of the `tictactoe` core. It arbitrates move requests from two player ports (X, O) using valid/ready handshakes and enforces strict alternation.
- It validates coordinates and cell occupancy against the core's board, issues a one-cycle `make_move` to the core, waits for the core to settle, then reports per-move status and game result.
- It also owns core reset and game restart, and forfeits a player who idles past a timeout.

Parameters:
- SETTLE_CYCLES, 3, cycles waited after make_move before sampling core_winner/core_tie (>=1).
- TIMEOUT_CYCLES, 1000, cycles the active player may idle in WAIT before forfeit (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- new_game  in  1  sync restart pulse; same effect as rst.
- p1_valid  in  1  player X move request.
- p1_x  in  4  X row.
- p1_y  in  4  X column.
- p1_ready  out  1  X request accepted this cycle when p1_valid&p1_ready.
- p2_valid  in  1  player O move request.
- p2_x  in  4  O row.
- p2_y  in  4  O column.
- p2_ready  out  1  O accept.
- core_rst_n  out  1  core reset, active-low.
- core_x  out  4  row to core.
- core_y  out  4  column to core.
- core_make_move  out  1  one-cycle move strobe to core.
- core_board  in  18  core board; cell k=3*x+y at bits [17-2k:16-2k]; 00 empty, 01 X, 10 O.
- core_winner  in  2  core winner (00 none, 01 X, 10 O).
- core_tie  in  1  core tie flag.
- resp_valid  out  1  one-cycle status pulse.
- resp_player  out  2  player the status refers to (01 X, 10 O).
- resp_code  out  3  0 OK, 1 BAD_COORD, 2 OCCUPIED, 3 GAME_OVER, 4 TIMEOUT.
- turn  out  2  player to move (01 X, 10 O).
- move_count  out  4  accepted legal moves, 0..9.
- game_over  out  1  high in DONE.
- result  out  2  00 none, 01 X wins, 10 O wins, 11 tie.

Behaviour:
- Reset (rst or new_game, any state, including mid-SETTLE):
  - Next state CLEAR.
  - Outputs: core_rst_n=0, core_make_move=0, core_x=core_y=0, resp_valid=0, resp_code=0, resp_player=0, turn=01, move_count=0, game_over=0, result=00, p1_ready=p2_ready=0, timeout counter=0.
  - A pending accepted move is discarded without a response.
- CLEAR: holds core_rst_n=0 for exactly 2 cycles, then core_rst_n=1 and state goes to WAIT.
- WAIT:
  - Ready is asserted only to the active player: p1_ready=(turn==01), p2_ready=(turn==10). The off-turn valid is ignored and never times out.
  - On handshake at cycle T: latch coords, go to CHECK.
  - Timeout counter increments each WAIT cycle without a handshake and clears on handshake.
  - When the counter reaches TIMEOUT_CYCLES-1 with no handshake: result=the other player, resp pulse code 4 with resp_player=active player, go to DONE.
- CHECK (T+1):
  - If x>2 or y>2: code 1.
  - Else if the cell is non-zero in core_board: code 2.
  - On error: resp pulse at T+2, turn unchanged, return to WAIT.
  - Otherwise go to ISSUE.
- ISSUE (T+2): core_make_move=1 for exactly one cycle, with core_x/core_y = latched coords held from ISSUE through EVAL.
- SETTLE: T+3 .. T+2+SETTLE_CYCLES.
- EVAL (T+3+SETTLE_CYCLES):
  - move_count+1; resp pulse code 0 at T+4+SETTLE_CYCLES.
  - If core_winner!=00: result=core_winner, go to DONE.
  - Else if core_tie or the new move_count==9: result=11, go to DONE.
  - Else toggle turn, go to WAIT.
- DONE:
  - game_over=1; p1_ready=p2_ready=1.
  - Any handshake yields a resp pulse code 3 with resp_player=requester the next cycle. If both request in the same cycle, respond to X first, then O.
  - No core_make_move; stays in DONE until rst/new_game.
- resp_valid is never high for two consecutive cycles from one event. The ready of the accepting player drops the cycle after a handshake.
- The core is never strobed for a move that fails validation.

Test Plan:
- rst 1 cycle, then X(0,0) -> core_rst_n low 2 cycles; accept; core_make_move pulse 2 cycles after accept; resp OK/X at T+7 (SETTLE_CYCLES=3); move_count=1; turn=10.
- O request during X's turn -> p2_ready=0, no strobe; X(3,1) -> resp code 1, turn stays 01; X(0,0) again after legal X(0,0), O's turn: O(0,0) -> code 2, no strobe.
- X(0,0) O(1,0) X(0,1) O(1,1) X(0,2) with core_winner=01 -> result=01, game_over=1; subsequent O request -> code 3, ready high, no strobe.
- Full 9-move draw -> move_count=9, result=11.
- X idles 1000 cycles -> resp code 4, resp_player=01, result=10, game_over=1.
- new_game asserted during SETTLE -> state CLEAR, no response for the pending move, move_count=0, turn=01.
